// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment constants, FSM state type and decimal helper for seg7_capture
package seg7_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {
      ST_EMPTY,
      ST_TRACK
   } state_t;

   function automatic logic [6:0] bcd_to_dec(input logic [3:0] tens, input logic [3:0] units);
      return 7'(tens) * 7'd10 + 7'(units);
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - active-low 7-segment pattern to {valid, digit}
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic       valid,
   output logic [3:0] digit
);

   always_comb begin
      valid = 1'b1;
      digit = 4'd0;
      case (seg)
         SEG_0:   digit = 4'd0;
         SEG_1:   digit = 4'd1;
         SEG_2:   digit = 4'd2;
         SEG_3:   digit = 4'd3;
         SEG_4:   digit = 4'd4;
         SEG_5:   digit = 4'd5;
         SEG_6:   digit = 4'd6;
         SEG_7:   digit = 4'd7;
         SEG_8:   digit = 4'd8;
         SEG_9:   digit = 4'd9;
         default: valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - debounced two-digit 7-segment capture with step tracking
// Optional input synchronizer: define SEG7_CAPTURE_SYNC_EN.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [6:0] HEX0_IN,
   input  logic [6:0] HEX1_IN,
   input  logic       clr,
   output logic [3:0] BCD0,
   output logic [3:0] BCD1,
   output logic       new_val,
   output logic       dir_up,
   output logic       dir_dn,
   output logic       step_err,
   output logic       pat_err
);

   localparam logic [7:0] EVAL_CNT = 8'(STABLE_CYCLES - 1);

   logic [13:0] pair_in;
   logic [13:0] pair_q;
   logic [7:0]  cnt_q;
   logic        eval;

`ifdef SEG7_CAPTURE_SYNC_EN
   logic [13:0] sync1_q;
   logic [13:0] sync2_q;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         sync1_q <= {SEG_BLANK, SEG_BLANK};
         sync2_q <= {SEG_BLANK, SEG_BLANK};
      end else begin
         sync1_q <= {HEX1_IN, HEX0_IN};
         sync2_q <= sync1_q;
      end
   end

   assign pair_in = sync2_q;
`else
   assign pair_in = {HEX1_IN, HEX0_IN};
`endif

   // The edge that brings the counter to STABLE_CYCLES is the only evaluation edge.
   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         pair_q <= {SEG_BLANK, SEG_BLANK};
         cnt_q  <= 8'd0;
      end else begin
         pair_q <= pair_in;
         if (pair_in != pair_q)
            cnt_q <= 8'd1;
         else if (cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
      end
   end

   assign eval = (pair_in == pair_q) && (cnt_q == EVAL_CNT);

   logic       valid0, valid1;
   logic [3:0] digit0, digit1;

   seg7_decode u_dec0 (.seg(pair_q[6:0]),  .valid(valid0), .digit(digit0));
   seg7_decode u_dec1 (.seg(pair_q[13:7]), .valid(valid1), .digit(digit1));

   logic [6:0] new_dec, held_dec, up_dec, dn_dec;

   assign new_dec  = bcd_to_dec(digit1, digit0);
   assign held_dec = bcd_to_dec(BCD1, BCD0);
   assign up_dec   = (held_dec == 7'd99) ? 7'd0  : held_dec + 7'd1;
   assign dn_dec   = (held_dec == 7'd0)  ? 7'd99 : held_dec - 7'd1;

   state_t     state_q, state_d;
   logic [3:0] bcd0_d, bcd1_d;
   logic       new_val_d, dir_up_d, dir_dn_d, step_ev, pat_ev;

   always_comb begin
      state_d   = state_q;
      bcd0_d    = BCD0;
      bcd1_d    = BCD1;
      new_val_d = 1'b0;
      dir_up_d  = 1'b0;
      dir_dn_d  = 1'b0;
      step_ev   = 1'b0;
      pat_ev    = 1'b0;
      if (eval) begin
         if (!(valid0 && valid1)) begin
            pat_ev = 1'b1;
         end else if (new_dec != held_dec) begin
            bcd0_d    = digit0;
            bcd1_d    = digit1;
            new_val_d = 1'b1;
            state_d   = ST_TRACK;
            // The first value after EMPTY has no predecessor to step from.
            if (state_q == ST_TRACK) begin
               if (new_dec == up_dec)
                  dir_up_d = 1'b1;
               else if (new_dec == dn_dec)
                  dir_dn_d = 1'b1;
               else
                  step_ev = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_EMPTY;
         BCD0     <= 4'd0;
         BCD1     <= 4'd0;
         new_val  <= 1'b0;
         dir_up   <= 1'b0;
         dir_dn   <= 1'b0;
         step_err <= 1'b0;
         pat_err  <= 1'b0;
      end else begin
         state_q  <= state_d;
         BCD0     <= bcd0_d;
         BCD1     <= bcd1_d;
         new_val  <= new_val_d;
         dir_up   <= dir_up_d;
         dir_dn   <= dir_dn_d;
         step_err <= (step_err & ~clr) | step_ev;
         pat_err  <= (pat_err & ~clr) | pat_ev;
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed self-checking bench for seg7_capture
module tb_seg7_capture;
   import seg7_pkg::*;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic [6:0] HEX0_IN, HEX1_IN;
   logic       clr;
   logic [3:0] BCD0, BCD1;
   logic       new_val, dir_up, dir_dn, step_err, pat_err;

   int n_checks = 0;
   int n_errors = 0;

   seg7_capture #(.STABLE_CYCLES(4)) dut (
      .CLOCK_50(CLOCK_50),
      .reset   (reset),
      .HEX0_IN (HEX0_IN),
      .HEX1_IN (HEX1_IN),
      .clr     (clr),
      .BCD0    (BCD0),
      .BCD1    (BCD1),
      .new_val (new_val),
      .dir_up  (dir_up),
      .dir_dn  (dir_dn),
      .step_err(step_err),
      .pat_err (pat_err)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return SEG_0;
         1: return SEG_1;
         2: return SEG_2;
         3: return SEG_3;
         4: return SEG_4;
         5: return SEG_5;
         6: return SEG_6;
         7: return SEG_7;
         8: return SEG_8;
         9: return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

   task automatic drive(input logic [6:0] h1, input logic [6:0] h0);
      @(negedge CLOCK_50);
      HEX1_IN = h1;
      HEX0_IN = h0;
   endtask

   task automatic hold_raw(input logic [6:0] h1, input logic [6:0] h0, input int n);
      drive(h1, h0);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic hold_dec(input int v, input int n);
      hold_raw(seg_of(v / 10), seg_of(v % 10), n);
   endtask

   task automatic chk_out(input string tag, input int v, input int nv, input int up, input int dn);
      chk({tag, ".bcd"},     int'(BCD1) * 10 + int'(BCD0), v);
      chk({tag, ".new_val"}, int'(new_val), nv);
      chk({tag, ".dir_up"},  int'(dir_up), up);
      chk({tag, ".dir_dn"},  int'(dir_dn), dn);
   endtask

   task automatic pulse_clr();
      @(negedge CLOCK_50);
      clr = 1'b1;
      @(posedge CLOCK_50);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      clr     = 1'b0;
      HEX1_IN = SEG_1;
      HEX0_IN = SEG_2;
      #3 reset = 1'b0;
      #2;
      chk_out("reset", 0, 0, 0, 0);
      chk("reset.step_err", int'(step_err), 0);
      chk("reset.pat_err", int'(pat_err), 0);

      // 12 after reset: accepted on the 4th edge only, no direction
      @(negedge CLOCK_50);
      reset = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk_out("first.early", 0, 0, 0, 0);
      @(posedge CLOCK_50);
      #1;
      chk_out("first", 12, 1, 0, 0);
      chk("first.state", int'(dut.state_q), int'(ST_TRACK));
      @(posedge CLOCK_50);
      #1;
      chk("first.pulse_end", int'(new_val), 0);

      // 3-cycle glitch to 88 is ignored
      hold_dec(88, 3);
      chk_out("glitch", 12, 0, 0, 0);
      hold_dec(12, 4);
      chk_out("glitch.back", 12, 0, 0, 0);
      chk("glitch.step_err", int'(step_err), 0);
      chk("glitch.pat_err", int'(pat_err), 0);

      hold_dec(13, 4);
      chk_out("up13", 13, 1, 1, 0);
      hold_dec(12, 4);
      chk_out("dn12", 12, 1, 0, 1);

      hold_dec(15, 4);
      chk_out("jump15", 15, 1, 0, 0);
      chk("jump15.step_err", int'(step_err), 1);
      pulse_clr();
      chk("clr.step_err", int'(step_err), 0);

      hold_dec(99, 4);
      chk_out("jump99", 99, 1, 0, 0);
      chk("jump99.step_err", int'(step_err), 1);
      pulse_clr();
      chk("clr2.step_err", int'(step_err), 0);

      hold_dec(0, 4);
      chk_out("wrap_up", 0, 1, 1, 0);
      hold_dec(99, 4);
      chk_out("wrap_dn", 99, 1, 0, 1);
      chk("wrap.step_err", int'(step_err), 0);

      // blank units digit: pattern error, value held
      hold_raw(SEG_9, SEG_BLANK, 4);
      chk_out("blank", 99, 0, 0, 0);
      chk("blank.pat_err", int'(pat_err), 1);

      // clr coinciding with another invalid evaluation: set wins
      drive(SEG_9, 7'b1010101);
      repeat (3) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      clr = 1'b1;
      @(posedge CLOCK_50);
      #1;
      clr = 1'b0;
      chk("setwins.pat_err", int'(pat_err), 1);
      chk_out("setwins", 99, 0, 0, 0);
      pulse_clr();
      chk("clr.pat_err", int'(pat_err), 0);

      // reset during cycle 2 of a stable 45
      drive(SEG_4, SEG_5);
      repeat (2) @(posedge CLOCK_50);
      #5 reset = 1'b0;
      #1;
      chk_out("midreset", 0, 0, 0, 0);
      chk("midreset.state", int'(dut.state_q), int'(ST_EMPTY));
      @(negedge CLOCK_50);
      reset = 1'b1;
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk_out("postreset.early", 0, 0, 0, 0);
      @(posedge CLOCK_50);
      #1;
      chk_out("postreset", 45, 1, 0, 0);
      chk("postreset.step_err", int'(step_err), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
